// File: rtl/uart_pkg.sv
// Shared constants and types for the 16x-oversampled UART receive/transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  localparam int SYS_CLK_HZ = 50_000_000;
  localparam int BAUD       = 9600;
  // Rounded divide: 50 MHz / 153600 = 325.5 -> 326
  localparam int DEF_CLK_DIV = (SYS_CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick: one-cycle pulse every CLK_DIV system clocks.
module uart_os_tick #(
  parameter int CLK_DIV = 326
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (reset)                tick_cnt <= '0;
    else if (tick_cnt == LAST) tick_cnt <= '0;
    else                      tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, one-entry valid/ready output register,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  logic rx_m, rx_s;
  logic tick;
  uart_state_t state, state_nxt;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic os_mid, os_last, bit_last;
  logic os_clr, os_inc, bit_clr, bit_inc, shift_en, byte_done, stop_bad;
  logic accept;

  // Idle-high reset value keeps the line from looking like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_os_tick #(.CLK_DIV(CLK_DIV)) u_os_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign os_mid   = (os_cnt == 4'(MID_SAMPLE));
  assign os_last  = (os_cnt == 4'(OVERSAMPLE - 1));
  assign bit_last = (bit_cnt == 3'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        IDLE:    if (!rx_s) state_nxt = START;
        START:   if (os_mid) state_nxt = rx_s ? IDLE : DATA;
        DATA:    if (os_last && bit_last) state_nxt = STOP;
        STOP:    if (os_last) state_nxt = rx_s ? IDLE : BREAK;
        BREAK:   if (rx_s) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    os_clr    = 1'b0;
    os_inc    = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    busy      = (state != IDLE);
    if (tick) begin
      unique case (state)
        IDLE:  os_clr = !rx_s;
        START: begin
          os_inc  = !os_mid;
          os_clr  = os_mid;
          bit_clr = os_mid;
        end
        DATA: begin
          os_inc   = !os_last;
          os_clr   = os_last;
          shift_en = os_last;
          bit_inc  = os_last && !bit_last;
        end
        STOP: begin
          os_inc    = !os_last;
          os_clr    = os_last;
          byte_done = os_last && rx_s;
          stop_bad  = os_last && !rx_s;
        end
        default: ;
      endcase
    end
  end

  assign accept = data_valid && data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (os_clr)      os_cnt <= '0;
      else if (os_inc) os_cnt <= os_cnt + 1'b1;
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      // A same-cycle accept frees the register, so the new byte loads instead of overrunning
      if (byte_done) begin
        if (!data_valid || accept) begin
          data       <= shreg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLK_DIV = 4 (64 clk per bit).
module tb_uart_rx;

  localparam int CLK_DIV = 4;
  localparam int BIT_CLK = CLK_DIV * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Scoreboard side: every transfer is compared against the oldest byte sent
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
      if (data_valid && data_ready) begin
        logic [7:0] e;
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL accept_unexpected: got %02h, expected no transfer", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL accept_data: got %02h expected %02h", data, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(BIT_CLK);
    end
    rx = stop;
    wait_clk(BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic drain();
    data_ready = 1'b1;
    wait_clk(3);
    data_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       ready;
    logic       push;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         ferr_d;
    int         ovr_d;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int f0, o0, a0;
    logic [7:0] b5a;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 0};
    vecs[3] = '{8'hC3, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1};

    // Reset state
    wait_clk(3);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    wait_clk(10);

    // 0xA5 with consumer stalled; frame ends 640 clk after its start edge
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("a5_valid", data_valid, 1);
    check("a5_data", data, 8'hA5);
    check("a5_ferr", ferr_cnt, 0);
    check("a5_busy", busy, 0);
    drain();
    check("a5_cleared", data_valid, 0);
    check("a5_accepts", acc_cnt, 1);

    // Back-to-back frames, then an overrun
    for (int i = 0; i < 4; i++) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      data_ready = vecs[i].ready;
      if (vecs[i].push) exp_q.push_back(vecs[i].b);
      send_frame(vecs[i].b, 1'b1);
      check($sformatf("vec%0d_valid", i), data_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].ferr_d);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, vecs[i].ovr_d);
    end
    check("b2b_accepts", acc_cnt, 3);
    drain();
    check("ovr_accepts", acc_cnt, 4);

    // Framing error followed by a held-low break
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_clk(3 * BIT_CLK);
    check("brk_busy", busy, 1);
    rx = 1'b1;
    wait_clk(BIT_CLK);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_valid", data_valid, 0);
    check("ferr_idle", busy, 0);
    exp_q.push_back(8'h81);
    data_ready = 1'b1;
    send_frame(8'h81, 1'b1);
    wait_clk(4);
    data_ready = 1'b0;
    check("post_ferr_accepts", acc_cnt, 5);

    // Start glitch of 3 ticks
    f0 = ferr_cnt;
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    wait_clk(20);
    check("glitch_busy_mid", busy, 1);
    wait_clk(80);
    check("glitch_idle", busy, 0);
    check("glitch_valid", data_valid, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);

    // Reset in the middle of bit 4 of 0x5A
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    a0 = acc_cnt;
    b5a = 8'h5A;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      wait_clk(BIT_CLK);
    end
    rx = b5a[4];
    wait_clk(BIT_CLK / 2);
    reset = 1'b1;
    wait_clk(1);
    check("mid_rst_data", data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    rx = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);
    check("abort_valid", data_valid, 0);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    check("r99_valid", data_valid, 1);
    check("r99_data", data, 8'h99);
    drain();
    check("r99_accepts", acc_cnt - a0, 1);
    check("r99_ferr", ferr_cnt - f0, 0);
    check("r99_ovr", ovr_cnt - o0, 0);
    check("queue_empty", exp_q.size(), 0);
    check("total_ovr", ovr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that serially decodes 8N1 frames from the `rx` line into bytes.
- It is the receive-side counterpart of the transmit path driven by our baud generator.
- Timing comes from an internal 16x oversampling tick derived from the system clock.
- Bytes are presented on a one-entry output register with a valid/ready handshake, plus framing-error and overrun indications.

Parameters:
- CLK_DIV, 326, system clocks per oversample tick (50 MHz / (9600 * 16), rounded); legal range >= 2.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  DATA_BITS  last received byte.
- data_valid  output  1  `data` holds an unconsumed byte.
- data_ready  input  1  consumer accepts `data`; transfer occurs when data_valid && data_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while data_valid was still high.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - data = 0, data_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - State = IDLE; all counters = 0; both synchronizer flops = 1.
  - Reset asserted mid-frame abandons the frame and emits no pulses.
- Synchronizer: `rx` passes through 2 flops (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- Tick:
  - tick_cnt counts 0..CLK_DIV-1, free-running, width $clog2(CLK_DIV).
  - tick is a 1-cycle pulse when tick_cnt == CLK_DIV-1.
  - All FSM actions happen only on tick cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK. os_cnt is 4 bits; bit_cnt is 3 bits.
  - IDLE: on tick with rx_s == 0 -> START, os_cnt = 0.
  - START: on each tick os_cnt++. When os_cnt == 7 (mid start bit):
    - rx_s == 0 -> DATA, os_cnt = 0, bit_cnt = 0.
    - rx_s == 1 -> IDLE (glitch rejected, no outputs).
  - DATA: on each tick os_cnt++. When os_cnt == 15:
    - Shift rx_s in LSB-first: shift register right-shifts, new bit enters at MSB (DATA_BITS-1).
    - os_cnt = 0.
    - If bit_cnt == DATA_BITS-1 -> STOP; else bit_cnt++.
  - STOP: when os_cnt == 15, sample rx_s:
    - 1: byte complete, go to IDLE. If data_valid == 0 (after any same-cycle accept), load data and set data_valid. Otherwise pulse overrun; data is unchanged and the new byte is dropped.
    - 0: pulse frame_err; data and data_valid are unchanged; -> BREAK.
  - BREAK: on tick with rx_s == 1 -> IDLE. A held-low line produces exactly one frame_err.
- Handshake:
  - data_valid clears on the cycle after data_valid && data_ready.
  - If an accept and a byte completion fall in the same cycle, the accept takes precedence: the new byte loads, data_valid stays 1, and no overrun is raised.
  - data_ready is ignored while data_valid == 0.
- Output timing: the data_valid rise, frame_err pulse and overrun pulse are all registered, asserting in the cycle after the STOP-sampling tick.
- Arithmetic: all counters wrap naturally, and the FSM resets them explicitly at each transition, so no saturation is needed.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - OVERSAMPLE = 16 and MID_SAMPLE = 7.
  - Default CLK_DIV derivation constants (SYS_CLK_HZ = 50_000_000, BAUD = 9600).
- One sub-module, uart_os_tick: parameter CLK_DIV; ports clk, reset, tick. It is also reusable by a future 16x transmit path.

Test Plan:
- All cases use CLK_DIV = 4, giving 64 clk per bit.
- Byte 0xA5: send 8N1 frame, data_ready held 0 -> data = 0xA5, data_valid = 1 within 64*10 + 8 clk of the start edge; frame_err = 0, busy returns to 0.
- Back-to-back: frames 0x00 then 0xFF with data_ready = 1 -> two accepts observed with values 0x00 and 0xFF; no overrun.
- Overrun: send 0x3C, keep data_ready = 0, then send 0xC3 -> single overrun pulse, data remains 0x3C, data_valid stays 1.
- Framing error: send 0x55 with stop bit low, then hold rx low for 3 bit times, then release high -> exactly one frame_err pulse; data_valid stays 0; FSM in IDLE after release; a following 0x81 frame is received correctly.
- Glitch: rx low for 3 ticks (12 clk) then high -> FSM returns to IDLE; no data_valid and no frame_err.
- Reset mid-frame: assert reset during bit 4 of 0x5A, release, then send 0x99 -> no output from the aborted frame; 0x99 received; all outputs are 0 during reset.
